// File: rtl/gsim_x_drain.sv
// gsim_x_drain: drain stage behind the Gauss-Seidel iteration core.
//
// This block captures one N-entry solution burst (Q16.16) into a local buffer.
// It then streams each entry to the host over a valid/ready handshake. Each entry
// is rounded half up and saturated to a signed OW-bit integer on the way out.
// The block also flags two protocol faults:
//   - a burst that ends early (short burst)
//   - a burst that arrives while the previous one is still draining (overrun)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   x_valid_in   burst qualifier (core out_valid)
//   x_in         Q16.16 solution value (core x_out)
//   m_valid      output word valid
//   m_ready      sink ready; transfer on m_valid && m_ready
//   m_data       rounded, saturated x[m_index]
//   m_index      element index 0..N-1
//   m_last       high with m_valid on element N-1
//   m_sat        current word was saturated
//   done         one-cycle pulse after the last element is accepted
//   err_short    sticky: burst ended before N samples (cleared at next burst start)
//   err_overrun  sticky: x_valid_in seen while draining (cleared only by reset)
//   busy         high while capturing or draining
module gsim_x_drain #(
    parameter int unsigned N  = 16,
    parameter int unsigned XW = 32,
    parameter int unsigned OW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid_in,
    input  logic [XW-1:0] x_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data,
    output logic [3:0]    m_index,
    output logic          m_last,
    output logic          m_sat,
    output logic          done,
    output logic          err_short,
    output logic          err_overrun,
    output logic          busy
);

    localparam int unsigned CW = $clog2(N + 1);
    // Width of (x + 2^15) >>> 16 taken in XW+1 bit arithmetic.
    localparam int unsigned RW = XW - 15;
    localparam logic signed [RW-1:0] SatHi = {{(RW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [RW-1:0] SatLo = {{(RW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDrain
    } state_e;

    // Returns {sat, data}.
    function automatic logic [OW:0] convert(input logic [XW-1:0] x);
        logic signed [XW:0]   t;
        logic signed [RW-1:0] r;
        t = $signed({x[XW-1], x}) + $signed((XW + 1)'(32768));
        r = RW'(t >>> 16);
        if (r > SatHi) begin
            convert = {1'b1, SatHi[OW-1:0]};
        end else if (r < SatLo) begin
            convert = {1'b1, SatLo[OW-1:0]};
        end else begin
            convert = {1'b0, r[OW-1:0]};
        end
    endfunction

    state_e        r_state;
    logic [CW-1:0] r_wr_cnt;
    logic [3:0]    r_rd_idx;
    logic          r_m_valid;
    logic [OW-1:0] r_m_data;
    logic [3:0]    r_m_index;
    logic          r_m_last;
    logic          r_m_sat;
    logic          r_done;
    logic          r_err_short;
    logic          r_err_overrun;
    logic [XW-1:0] r_buf [N];

    state_e        w_state_nxt;
    logic [CW-1:0] w_wr_cnt_nxt;
    logic [3:0]    w_rd_idx_nxt;
    logic          w_m_valid_nxt;
    logic [OW-1:0] w_m_data_nxt;
    logic [3:0]    w_m_index_nxt;
    logic          w_m_last_nxt;
    logic          w_m_sat_nxt;
    logic          w_done_nxt;
    logic          w_err_short_nxt;
    logic          w_err_overrun_nxt;
    logic          w_buf_we;
    logic [3:0]    w_buf_addr;
    logic [3:0]    w_rd_sel;
    logic [OW:0]   w_conv;

    // Word presented next is converted straight from the buffer so that the
    // registered outputs carry no extra latency.
    assign w_conv = convert(r_buf[w_rd_sel]);

    always_comb begin
        w_state_nxt       = r_state;
        w_wr_cnt_nxt      = r_wr_cnt;
        w_rd_idx_nxt      = r_rd_idx;
        w_m_valid_nxt     = r_m_valid;
        w_m_data_nxt      = r_m_data;
        w_m_index_nxt     = r_m_index;
        w_m_last_nxt      = r_m_last;
        w_m_sat_nxt       = r_m_sat;
        w_done_nxt        = 1'b0;
        w_err_short_nxt   = r_err_short;
        w_err_overrun_nxt = r_err_overrun;
        w_buf_we          = 1'b0;
        w_buf_addr        = r_wr_cnt[3:0];
        w_rd_sel          = 4'd0;

        unique case (r_state)
            StIdle: begin
                if (x_valid_in) begin
                    w_buf_we        = 1'b1;
                    w_buf_addr      = 4'd0;
                    w_wr_cnt_nxt    = CW'(1);
                    w_err_short_nxt = 1'b0;
                    w_state_nxt     = StCapture;
                end
            end
            StCapture: begin
                if (x_valid_in) begin
                    w_buf_we     = 1'b1;
                    w_wr_cnt_nxt = r_wr_cnt + CW'(1);
                    if (r_wr_cnt == CW'(N - 1)) begin
                        // Last sample written this edge; present element 0 on the same edge.
                        w_state_nxt   = StDrain;
                        w_wr_cnt_nxt  = '0;
                        w_rd_idx_nxt  = 4'd0;
                        w_rd_sel      = 4'd0;
                        w_m_valid_nxt = 1'b1;
                        w_m_data_nxt  = w_conv[OW-1:0];
                        w_m_sat_nxt   = w_conv[OW];
                        w_m_index_nxt = 4'd0;
                        w_m_last_nxt  = (N == 1);
                    end
                end else begin
                    // Gap or early end: drop the partial burst.
                    w_err_short_nxt = 1'b1;
                    w_wr_cnt_nxt    = '0;
                    w_state_nxt     = StIdle;
                end
            end
            StDrain: begin
                if (x_valid_in) begin
                    w_err_overrun_nxt = 1'b1;
                end
                if (r_m_valid && m_ready) begin
                    if (r_rd_idx == 4'(N - 1)) begin
                        w_m_valid_nxt = 1'b0;
                        w_m_data_nxt  = '0;
                        w_m_index_nxt = 4'd0;
                        w_m_last_nxt  = 1'b0;
                        w_m_sat_nxt   = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = StIdle;
                    end else begin
                        w_rd_sel      = r_rd_idx + 4'd1;
                        w_rd_idx_nxt  = r_rd_idx + 4'd1;
                        w_m_data_nxt  = w_conv[OW-1:0];
                        w_m_sat_nxt   = w_conv[OW];
                        w_m_index_nxt = r_rd_idx + 4'd1;
                        w_m_last_nxt  = (r_rd_idx == 4'(N - 2));
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_wr_cnt      <= '0;
            r_rd_idx      <= '0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_index     <= '0;
            r_m_last      <= 1'b0;
            r_m_sat       <= 1'b0;
            r_done        <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_cnt      <= w_wr_cnt_nxt;
            r_rd_idx      <= w_rd_idx_nxt;
            r_m_valid     <= w_m_valid_nxt;
            r_m_data      <= w_m_data_nxt;
            r_m_index     <= w_m_index_nxt;
            r_m_last      <= w_m_last_nxt;
            r_m_sat       <= w_m_sat_nxt;
            r_done        <= w_done_nxt;
            r_err_short   <= w_err_short_nxt;
            r_err_overrun <= w_err_overrun_nxt;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[w_buf_addr] <= x_in;
        end
    end

    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_index     = r_m_index;
    assign m_last      = r_m_last;
    assign m_sat       = r_m_sat;
    assign done        = r_done;
    assign err_short   = r_err_short;
    assign err_overrun = r_err_overrun;
    assign busy        = (r_state != StIdle);

endmodule
